// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types for the parametrised up/down counter
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } cnt_state_e;

endpackage

// File: rtl/param_updown_counter_if.sv
// rtl/param_updown_counter_if.sv - control/status bundle of the up/down counter
interface param_updown_counter_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
);
  logic                  en;
  logic                  chnge;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [WIDTH-1:0]      limit;
  logic [1:0]            mode;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      out;
  logic                  tc;
  logic                  done;
  logic                  busy;
  logic                  err;

  modport master (
    output en, chnge, load, load_val, limit, mode, prescale,
    input  out, tc, done, busy, err
  );

  modport slave (
    input  en, chnge, load, load_val, limit, mode, prescale,
    output out, tc, done, busy, err
  );
endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - clock-enable divider, one tick every prescale+1 running cycles
module tick_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  assign tick = run && (pcnt == prescale);

  // A lowered prescale below pcnt is recovered by natural wrap of pcnt.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (clr || tick) begin
      pcnt <= '0;
    end else if (run) begin
      pcnt <= pcnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - up/down counter with terminal value, modes, prescaler and load
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  param_updown_counter_if.slave bus
);

  cnt_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cnt_inc, cnt_dec;
  logic             tc_q, tc_d;
  logic             err_q, err_d;
  logic             done_q, busy_q;
  logic             tick, step, term, up, run, clr;
  mode_e            mode_s;

  assign mode_s  = mode_e'(bus.mode);
  assign up      = bus.chnge;
  assign cnt_inc = cnt_q + WIDTH'(1);
  assign cnt_dec = cnt_q - WIDTH'(1);
  assign run     = (state_q == S_RUN);
  assign clr     = bus.load || !bus.en;

  // Above-limit values (limit lowered mid-count) are terminal when counting up.
  assign term = up ? (cnt_q >= bus.limit) : (cnt_q == '0);
  assign step = tick && bus.en && !bus.load;

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .CLK      (CLK),
    .reset    (reset),
    .run      (run),
    .clr      (clr),
    .prescale (bus.prescale),
    .tick     (tick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.en) state_d = S_RUN;
      end
      S_RUN: begin
        if (!bus.en) begin
          state_d = S_IDLE;
        end else if (step && term && (mode_s == MODE_ONESHOT)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.load || (mode_s != MODE_ONESHOT)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    err_d = 1'b0;
    if (bus.load) begin
      if (bus.load_val > bus.limit) begin
        cnt_d = bus.limit;
        err_d = 1'b1;
      end else begin
        cnt_d = bus.load_val;
      end
    end else if (step) begin
      if (!term) begin
        if (up) begin
          cnt_d = cnt_inc;
          tc_d  = (cnt_inc >= bus.limit);
        end else begin
          cnt_d = cnt_dec;
          tc_d  = (cnt_dec == '0);
        end
      end else begin
        case (mode_s)
          MODE_SAT, MODE_ONESHOT: cnt_d = cnt_q;
          default:                cnt_d = up ? '0 : bus.limit;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
      done_q  <= (state_d == S_DONE);
      busy_q  <= (state_d == S_RUN);
    end
  end

  assign bus.out  = cnt_q;
  assign bus.tc   = tc_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - scoreboard bench for param_updown_counter
module tb_param_updown_counter;
  import counter_pkg::*;

  localparam int W  = 4;
  localparam int PW = 4;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  param_updown_counter_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

  param_updown_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    int         cyc;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  function automatic logic [7:0] observed();
    return {bus.out, bus.tc, bus.done, bus.busy, bus.err};
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got out=%0d tc/done/busy/err=%b, want out=%0d tc/done/busy/err=%b",
               nm, act[7:4], act[3:0], exp[7:4], exp[3:0]);
    end
  endtask

  // Expectation for the state after the next rising edge; inputs are already set.
  task automatic ex(input string nm, input int o, input bit t, input bit d, input bit b, input bit e);
    exp_t x;
    x.name = nm;
    x.cyc  = cyc + 1;
    x.exp  = {4'(o), t, d, b, e};
    sb.push_back(x);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not sampled, now cycle %0d",
                 sb[0].name, sb[0].cyc, cyc);
        sb.delete(0);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        mon_e = sb.pop_front();
        check(mon_e.name, observed(), mon_e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en       = 1'b0;
    bus.chnge    = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.limit    = 4'd9;
    bus.mode     = MODE_WRAP;
    bus.prescale = '0;
    reset        = 1'b1;
    @(posedge CLK);
    #1;
    check("reset_state", observed(), 8'h00);
    reset = 1'b0;

    ex("idle_hold", 0, 0, 0, 0, 0);
    bus.en = 1'b1;
    ex("idle_to_run", 0, 0, 0, 1, 0);
    for (int i = 1; i <= 9; i++) ex("wrap_up", i, (i == 9), 0, 1, 0);
    ex("wrap_to_zero", 0, 0, 0, 1, 0);
    for (int i = 1; i <= 7; i++) ex("count_to_7", i, 0, 0, 1, 0);

    #5;
    reset = 1'b1;
    #1;
    check("async_reset", observed(), 8'h00);
    ex("reset_hold", 0, 0, 0, 0, 0);
    reset  = 1'b0;
    bus.en = 1'b0;

    bus.mode     = MODE_SAT;
    bus.chnge    = 1'b0;
    bus.load     = 1'b1;
    bus.load_val = 4'd3;
    ex("sat_load", 3, 0, 0, 0, 0);
    bus.load = 1'b0;
    bus.en   = 1'b1;
    ex("sat_run", 3, 0, 0, 1, 0);
    ex("sat_down", 2, 0, 0, 1, 0);
    ex("sat_down", 1, 0, 0, 1, 0);
    ex("sat_tc", 0, 1, 0, 1, 0);
    ex("sat_hold", 0, 0, 0, 1, 0);
    ex("sat_hold", 0, 0, 0, 1, 0);
    bus.en = 1'b0;
    ex("sat_stop", 0, 0, 0, 0, 0);

    bus.mode     = MODE_ONESHOT;
    bus.chnge    = 1'b1;
    bus.limit    = 4'd5;
    bus.prescale = 4'd2;
    bus.load     = 1'b1;
    bus.load_val = 4'd0;
    ex("os_load", 0, 0, 0, 0, 0);
    bus.load = 1'b0;
    bus.en   = 1'b1;
    ex("os_run", 0, 0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      ex("os_wait", k - 1, 0, 0, 1, 0);
      ex("os_wait", k - 1, 0, 0, 1, 0);
      ex("os_step", k, (k == 5), 0, 1, 0);
    end
    ex("os_wait", 5, 0, 0, 1, 0);
    ex("os_wait", 5, 0, 0, 1, 0);
    ex("os_done", 5, 0, 1, 0, 0);
    ex("os_done_hold", 5, 0, 1, 0, 0);
    bus.load     = 1'b1;
    bus.load_val = 4'd0;
    bus.en       = 1'b0;
    ex("os_reload", 0, 0, 0, 0, 0);

    bus.mode     = MODE_WRAP;
    bus.limit    = 4'd9;
    bus.prescale = 4'd0;
    bus.load_val = 4'd12;
    ex("load_clamp", 9, 0, 0, 0, 1);
    bus.load = 1'b0;
    ex("err_pulse_end", 9, 0, 0, 0, 0);
    bus.limit    = 4'd15;
    bus.load     = 1'b1;
    bus.load_val = 4'd15;
    ex("load_at_limit", 15, 0, 0, 0, 0);
    bus.load_val = 4'd9;
    ex("load9", 9, 0, 0, 0, 0);
    bus.load = 1'b0;
    bus.en   = 1'b1;
    ex("run9", 9, 0, 0, 1, 0);
    ex("up10", 10, 0, 0, 1, 0);
    bus.load     = 1'b1;
    bus.load_val = 4'd2;
    ex("load_vs_tick", 2, 0, 0, 1, 0);
    bus.load = 1'b0;
    ex("up3", 3, 0, 0, 1, 0);
    ex("up4", 4, 0, 0, 1, 0);
    bus.chnge = 1'b0;
    ex("dir_down", 3, 0, 0, 1, 0);
    bus.chnge = 1'b1;
    ex("dir_up", 4, 0, 0, 1, 0);
    bus.limit = 4'd2;
    ex("limit_drop_wrap", 0, 0, 0, 1, 0);
    ex("low_limit_up", 1, 0, 0, 1, 0);
    ex("low_limit_tc", 2, 1, 0, 1, 0);
    ex("low_limit_wrap", 0, 0, 0, 1, 0);
    bus.chnge = 1'b0;
    ex("wrap_down", 2, 0, 0, 1, 0);
    ex("down1", 1, 0, 0, 1, 0);
    ex("down_tc", 0, 1, 0, 1, 0);
    bus.en = 1'b0;
    ex("final_stop", 0, 0, 0, 0, 0);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
